// File: rtl/arp_pkg.sv
// ARP controller shared types: FSM encoding, ARP frame type codes
// and the broadcast MAC used for requests.
package arp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_REPLY,
        WAIT_REPLY_DONE,
        TX_REQ,
        WAIT_REQ_DONE,
        WAIT_ANSWER
    } arp_state_e;

    localparam logic ARP_TYPE_REQ   = 1'b0;
    localparam logic ARP_TYPE_REPLY = 1'b1;

    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

    localparam int RETRY_W = 8;

endpackage

// File: rtl/arp_retry_timer.sv
// Answer timeout counter plus retransmission counter for arp_ctrl.
// expire_o flags the last cycle of a wait window.
module arp_retry_timer
    import arp_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o,
    output logic exhausted_o
);

    logic [31:0]        tmr_q;
    logic [RETRY_W-1:0] retry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q   <= '0;
            retry_q <= '0;
        end else begin
            if (clr_i) begin
                tmr_q <= '0;
            end else if (en_i) begin
                tmr_q <= tmr_q + 32'd1;
            end
            if (load_i) begin
                retry_q <= '0;
            end else if (inc_i) begin
                retry_q <= retry_q + 1'b1;
            end
        end
    end

    assign expire_o    = (tmr_q == TIMEOUT_CYC - 32'd1);
    assign exhausted_o = (retry_q == RETRY_W'(MAX_RETRY));

endmodule

// File: rtl/arp_ctrl.sv
// ARP control: answers incoming requests, resolves one target IP
// with retries, and keeps a single-entry IP/MAC cache.
module arp_ctrl
    import arp_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        req_start,
    input  logic [31:0] req_ip,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        tx_done,
    output logic        resolved,
    output logic [31:0] peer_ip,
    output logic [47:0] peer_mac,
    output logic        busy,
    output logic        fail
);

    arp_state_e  state_q;
    logic        tx_en_q;
    logic        tx_type_q;
    logic [47:0] des_mac_q;
    logic [31:0] des_ip_q;
    logic        resolved_q;
    logic [31:0] peer_ip_q;
    logic [47:0] peer_mac_q;
    logic        busy_q;
    logic        fail_q;
    logic        req_due_q;
    logic [31:0] tgt_ip_q;
    logic        reply_pend_q;
    logic [47:0] rpl_mac_q;
    logic [31:0] rpl_ip_q;
    logic        rx_vld_q;
    logic        rx_hit_q;
    logic        rx_rep_q;
    logic [47:0] rx_mac_q;
    logic [31:0] rx_ip_q;

    logic match_rx;
    logic match_live;
    logic in_wa;
    logic wa_hold;
    logic expire;
    logic exhausted;
    logic retry_go;
    logic fail_go;
    logic tmr_clr;
    logic tmr_en;
    logic ld;

    assign match_rx   = (arp_rx_type == ARP_TYPE_REPLY)
                     && (src_ip == tgt_ip_q) && busy_q;
    assign match_live = arp_rx_done && match_rx;
    assign in_wa      = (state_q == WAIT_ANSWER);
    // Anything below takes priority over a timeout in WAIT_ANSWER
    assign wa_hold    = match_live || !busy_q
                     || reply_pend_q || req_due_q;
    assign retry_go   = in_wa && !wa_hold && expire && !exhausted;
    assign fail_go    = in_wa && !wa_hold && expire && exhausted;
    assign tmr_clr    = (state_q == WAIT_REQ_DONE) && tx_done;
    assign tmr_en     = in_wa && !reply_pend_q;
    assign ld         = req_start && !busy_q;

    arp_retry_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (tmr_clr),
        .en_i        (tmr_en),
        .load_i      (ld),
        .inc_i       (retry_go),
        .expire_o    (expire),
        .exhausted_o (exhausted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_en_q      <= 1'b0;
            tx_type_q    <= ARP_TYPE_REQ;
            des_mac_q    <= '0;
            des_ip_q     <= '0;
            resolved_q   <= 1'b0;
            peer_ip_q    <= '0;
            peer_mac_q   <= '0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b0;
            req_due_q    <= 1'b0;
            tgt_ip_q     <= '0;
            reply_pend_q <= 1'b0;
            rpl_mac_q    <= '0;
            rpl_ip_q     <= '0;
            rx_vld_q     <= 1'b0;
            rx_hit_q     <= 1'b0;
            rx_rep_q     <= 1'b0;
            rx_mac_q     <= '0;
            rx_ip_q      <= '0;
        end else begin
            tx_en_q  <= 1'b0;
            fail_q   <= 1'b0;
            rx_vld_q <= arp_rx_done;
            rx_hit_q <= arp_rx_done
                     && (arp_rx_type == ARP_TYPE_REQ || match_rx);
            rx_rep_q <= (arp_rx_type == ARP_TYPE_REPLY);
            rx_mac_q <= src_mac;
            rx_ip_q  <= src_ip;

            if (state_q == TX_REPLY) begin
                reply_pend_q <= 1'b0;
            end
            if (arp_rx_done && arp_rx_type == ARP_TYPE_REQ) begin
                reply_pend_q <= 1'b1;
                rpl_mac_q    <= src_mac;
                rpl_ip_q     <= src_ip;
            end

            if (ld) begin
                tgt_ip_q   <= req_ip;
                resolved_q <= 1'b0;
                busy_q     <= 1'b1;
                req_due_q  <= 1'b1;
            end

            // Cache write lands one cycle after the rx pulse
            if (rx_vld_q && rx_hit_q) begin
                peer_ip_q  <= rx_ip_q;
                peer_mac_q <= rx_mac_q;
                resolved_q <= 1'b1;
                if (rx_rep_q) begin
                    busy_q    <= 1'b0;
                    req_due_q <= 1'b0;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (reply_pend_q) begin
                        state_q   <= TX_REPLY;
                        tx_en_q   <= 1'b1;
                        tx_type_q <= ARP_TYPE_REPLY;
                        des_mac_q <= rpl_mac_q;
                        des_ip_q  <= rpl_ip_q;
                    end else if (req_due_q) begin
                        state_q   <= TX_REQ;
                        tx_en_q   <= 1'b1;
                        tx_type_q <= ARP_TYPE_REQ;
                        des_mac_q <= BCAST_MAC;
                        des_ip_q  <= tgt_ip_q;
                        req_due_q <= 1'b0;
                    end
                end
                TX_REPLY: state_q <= WAIT_REPLY_DONE;
                WAIT_REPLY_DONE: begin
                    if (tx_done) begin
                        state_q <= busy_q ? WAIT_ANSWER : IDLE;
                    end
                end
                TX_REQ: state_q <= WAIT_REQ_DONE;
                WAIT_REQ_DONE: begin
                    if (tx_done) begin
                        state_q <= WAIT_ANSWER;
                    end
                end
                WAIT_ANSWER: begin
                    if (match_live || !busy_q) begin
                        state_q <= IDLE;
                    end else if (reply_pend_q) begin
                        state_q   <= TX_REPLY;
                        tx_en_q   <= 1'b1;
                        tx_type_q <= ARP_TYPE_REPLY;
                        des_mac_q <= rpl_mac_q;
                        des_ip_q  <= rpl_ip_q;
                    end else if (req_due_q || retry_go) begin
                        state_q   <= TX_REQ;
                        tx_en_q   <= 1'b1;
                        tx_type_q <= ARP_TYPE_REQ;
                        des_mac_q <= BCAST_MAC;
                        des_ip_q  <= tgt_ip_q;
                        req_due_q <= 1'b0;
                    end else if (fail_go) begin
                        state_q <= IDLE;
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arp_tx_en   = tx_en_q;
    assign arp_tx_type = tx_type_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;
    assign resolved    = resolved_q;
    assign peer_ip     = peer_ip_q;
    assign peer_mac    = peer_mac_q;
    assign busy        = busy_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with TIMEOUT_CYC=100, MAX_RETRY=2.
module tb_arp_ctrl;

    localparam int TO = 100;

    localparam logic [31:0] IP102 = 32'hc0a8_0166;
    localparam logic [31:0] IP103 = 32'hc0a8_0167;
    localparam logic [31:0] IP104 = 32'hc0a8_0168;
    localparam logic [31:0] IP105 = 32'hc0a8_0169;
    localparam logic [31:0] IP106 = 32'hc0a8_016a;
    localparam logic [31:0] IP50  = 32'hc0a8_0132;
    localparam logic [31:0] IP60  = 32'hc0a8_013c;
    localparam logic [47:0] MAC_A = 48'h0a0b_0c0d_0e0f;
    localparam logic [47:0] MAC_X = 48'h1122_3344_5566;
    localparam logic [47:0] MAC_Y = 48'h2233_4455_6677;
    localparam logic [47:0] MAC_Z = 48'h3344_5566_7788;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        req_start = 1'b0;
    logic [31:0] req_ip = '0;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        tx_done = 1'b0;
    logic        resolved;
    logic [31:0] peer_ip;
    logic [47:0] peer_mac;
    logic        busy;
    logic        fail;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int ntx   = 0;
    int nfail = 0;

    arp_ctrl #(
        .TIMEOUT_CYC (32'd100),
        .MAX_RETRY   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .req_start   (req_start),
        .req_ip      (req_ip),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .tx_done     (tx_done),
        .resolved    (resolved),
        .peer_ip     (peer_ip),
        .peer_mac    (peer_mac),
        .busy        (busy),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arp_tx_en) ntx++;
        if (fail) nfail++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [31:0] ip);
        req_start = 1'b1;
        req_ip    = ip;
        tick();
        req_start = 1'b0;
    endtask

    task automatic rx(input logic t,
                      input logic [47:0] mac,
                      input logic [31:0] ip);
        arp_rx_done = 1'b1;
        arp_rx_type = t;
        src_mac     = mac;
        src_ip      = ip;
        tick();
        arp_rx_done = 1'b0;
    endtask

    task automatic txd(output int k);
        tx_done = 1'b1;
        k = cyc;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int n;
        n = 0;
        while (!arp_tx_en && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(arp_tx_en), 64'd1);
    endtask

    // Request tx_done in cycle k: 100 counting cycles, then TX_REQ
    task automatic chk_gap(input string tag, input int k);
        int g;
        g = cyc - k;
        chk(tag, 64'(g >= TO && g <= TO + 1), 64'd1);
        if (!(g >= TO && g <= TO + 1))
            $display("  gap was %0d cycles", g);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        int f0;

        ticks(3);
        rst = 1'b0;
        chk("rst_txen", 64'(arp_tx_en), 64'd0);
        chk("rst_type", 64'(arp_tx_type), 64'd0);
        chk("rst_dmac", 64'(des_mac), 64'd0);
        chk("rst_dip", 64'(des_ip), 64'd0);
        chk("rst_res", 64'(resolved), 64'd0);
        chk("rst_pip", 64'(peer_ip), 64'd0);
        chk("rst_pmac", 64'(peer_mac), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        ticks(2);
        chk("idle_notx", 64'(ntx), 64'd0);

        // Basic resolve of .102
        t0 = ntx;
        start(IP102);
        chk("a_busy", 64'(busy), 64'd1);
        wait_tx("a_req", 10);
        chk("a_type", 64'(arp_tx_type), 64'd0);
        chk("a_dmac", 64'(des_mac), 64'hffff_ffff_ffff);
        chk("a_dip", 64'(des_ip), 64'(IP102));
        tick();
        chk("a_pulse1", 64'(arp_tx_en), 64'd0);
        chk("a_hold_dip", 64'(des_ip), 64'(IP102));
        ticks(3);
        txd(k);
        ticks(5);
        rx(1'b1, MAC_A, IP102);
        tick();
        chk("a_res", 64'(resolved), 64'd1);
        chk("a_pmac", 64'(peer_mac), 64'(MAC_A));
        chk("a_pip", 64'(peer_ip), 64'(IP102));
        chk("a_busy0", 64'(busy), 64'd0);
        ticks(150);
        chk("a_ntx", 64'(ntx - t0), 64'd1);

        // No answer: three requests then fail
        t0 = ntx;
        f0 = nfail;
        start(IP103);
        chk("b_res_clr", 64'(resolved), 64'd0);
        for (int a = 0; a < 3; a++) begin
            wait_tx("b_req", 150);
            chk("b_type", 64'(arp_tx_type), 64'd0);
            chk("b_dip", 64'(des_ip), 64'(IP103));
            if (a > 0) chk_gap("b_gap", k);
            ticks(2);
            txd(k);
        end
        begin
            int n;
            n = 0;
            while (!fail && n < 150) begin
                tick();
                n++;
            end
        end
        chk("b_fail", 64'(fail), 64'd1);
        chk_gap("b_fgap", k);
        chk("b_busy_f", 64'(busy), 64'd0);
        tick();
        chk("b_fail1", 64'(fail), 64'd0);
        ticks(150);
        chk("b_ntx", 64'(ntx - t0), 64'd3);
        chk("b_nfail", 64'(nfail - f0), 64'd1);

        // Incoming request in IDLE
        rx(1'b0, MAC_X, IP50);
        wait_tx("c_rpl", 5);
        chk("c_type", 64'(arp_tx_type), 64'd1);
        chk("c_dip", 64'(des_ip), 64'(IP50));
        chk("c_dmac", 64'(des_mac), 64'(MAC_X));
        chk("c_res", 64'(resolved), 64'd1);
        chk("c_pip", 64'(peer_ip), 64'(IP50));
        chk("c_pmac", 64'(peer_mac), 64'(MAC_X));
        ticks(2);
        txd(k);
        ticks(5);

        // Request arriving while our request is on the wire
        start(IP104);
        wait_tx("d_req", 10);
        tick();
        rx(1'b0, MAC_Y, IP60);
        ticks(2);
        txd(k);
        wait_tx("d_rpl", 10);
        chk("d_rtype", 64'(arp_tx_type), 64'd1);
        chk("d_rdip", 64'(des_ip), 64'(IP60));
        chk("d_rdmac", 64'(des_mac), 64'(MAC_Y));
        tick();
        txd(k);
        wait_tx("d_retry", 150);
        chk("d_qtype", 64'(arp_tx_type), 64'd0);
        chk("d_qdip", 64'(des_ip), 64'(IP104));
        chk_gap("d_gap", k);
        tick();
        txd(k);
        ticks(3);
        rx(1'b1, MAC_Z, IP104);
        tick();
        chk("d_busy0", 64'(busy), 64'd0);
        chk("d_pmac", 64'(peer_mac), 64'(MAC_Z));
        ticks(5);

        // Reply lands exactly on the final expiry cycle
        t0 = ntx;
        f0 = nfail;
        start(IP105);
        for (int a = 0; a < 3; a++) begin
            wait_tx("e_req", 150);
            tick();
            txd(k);
        end
        while (cyc < k + TO) tick();
        rx(1'b1, MAC_A, IP105);
        ticks(150);
        chk("e_nfail", 64'(nfail - f0), 64'd0);
        chk("e_ntx", 64'(ntx - t0), 64'd3);
        chk("e_res", 64'(resolved), 64'd1);
        chk("e_pip", 64'(peer_ip), 64'(IP105));
        chk("e_busy", 64'(busy), 64'd0);

        // Reset one cycle after a request pulse
        t0 = ntx;
        start(IP106);
        wait_tx("f_req", 10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_txen", 64'(arp_tx_en), 64'd0);
        chk("f_dmac", 64'(des_mac), 64'd0);
        chk("f_dip", 64'(des_ip), 64'd0);
        chk("f_busy", 64'(busy), 64'd0);
        chk("f_res", 64'(resolved), 64'd0);
        chk("f_pip", 64'(peer_ip), 64'd0);
        chk("f_pmac", 64'(peer_mac), 64'd0);
        ticks(2);
        txd(k);
        ticks(150);
        chk("f_ntx", 64'(ntx - t0), 64'd1);
        chk("f_fail", 64'(fail), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
